// File: rtl/jtcop_prot_pkg.sv
// Shared constants for the protection-MCU PROM loader: stream and PROM
// address widths, PROM length, counter widths and the FSM state encoding.
package jtcop_prot_pkg;

  localparam int IOCTL_AW = 22;   // download stream byte address width
  localparam int PROM_AW  = 9;    // PROM word address width
  localparam int PROM_LEN = 512;  // PROM length in bytes
  localparam int HW_W     = 10;   // high-water count, must hold PROM_LEN itself
  localparam int HOLD_W   = 16;   // holdoff counter width

  // FSM state encoding, kept as plain constants so older tools and
  // waveform viewers show the same codes.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_FILL = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/jtcop_prot_holdoff.sv
// Holdoff counter: loaded with a cycle count, counts down while enabled and
// flags done once it reaches zero. Clear drops both the count and the
// armed flag so done cannot be seen before the next load.
module jtcop_prot_holdoff
  import jtcop_prot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              en,
  output logic              done
);

  logic [HOLD_W-1:0] cnt;
  logic              armed;

  // Count register: clear wins over load, load wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (en && (cnt != '0)) begin
      cnt   <= cnt - HOLD_W'(1);
    end
  end

  assign done = armed && (cnt == '0);

endmodule

// File: rtl/jtcop_prot_loader.sv
// Protection-MCU PROM loader. Picks the 512-byte PROM image out of the ROM
// download stream, pads any unwritten tail with FF, then keeps the MCU in
// reset for a holdoff period before releasing it.
//
// Write strobe contract: prog_en is a one-cycle pulse; prog_addr and
// prog_data are valid in exactly the cycle prog_en is high. There is no
// back-pressure: the PROM must accept one write per cycle.
//
// Optional feature: define JTCOP_PROT_CKSUM_EN to add the cksum output
// (modulo-256 sum of all bytes written during the current load).
module jtcop_prot_loader
  import jtcop_prot_pkg::*;
#(
  parameter logic [IOCTL_AW-1:0] PROM_START = 22'h0,
  parameter int                  HOLDOFF    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                downloading,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic                ioctl_wr,
  output logic [PROM_AW-1:0]  prog_addr,
  output logic [7:0]          prog_data,
  output logic                prog_en,
  output logic                prot_rst,
  output logic                ready
`ifdef JTCOP_PROT_CKSUM_EN
  ,
  output logic [7:0]          cksum
`endif
);

  logic [1:0]          rst_sync;
  logic                run;
  logic                dl_last;
  logic                dl_rise;
  logic                dl_fall;
  state_t              state;
  logic [HW_W-1:0]     hw;
  logic [HW_W-1:0]     hw_next;
  logic [HW_W-1:0]     off_p1;
  logic [IOCTL_AW-1:0] off;
  logic                in_win;
  logic                wr_hit;
  logic                hw_full;
  logic                fill_last;
  logic                issue_load;
  logic                issue_fill;
  logic [7:0]          issue_data;
  logic                hold_load;
  logic                hold_done;

  // Reset release synchroniser; the FSM only moves once run is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  // Downloading edge detector. It starts at 1 so that a download already
  // in progress when reset is released is not joined half-way through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   dl_last <= 1'b1;
    else if (run) dl_last <= downloading;
  end

  assign dl_rise = run &&  downloading && !dl_last;
  assign dl_fall = run && !downloading &&  dl_last;

  // Window decode and high-water bookkeeping. hw_next already includes a
  // strobe that lands in the same cycle downloading falls, so the
  // FILL/DONE decision sees that last byte.
  always_comb begin
    off        = ioctl_addr - PROM_START;
    in_win     = (ioctl_addr >= PROM_START) && (off < IOCTL_AW'(PROM_LEN));
    wr_hit     = (state == ST_LOAD) && ioctl_wr && in_win;
    off_p1     = {1'b0, off[PROM_AW-1:0]} + HW_W'(1);
    hw_next    = (wr_hit && (off_p1 > hw)) ? off_p1 : hw;
    hw_full    = (hw_next == HW_W'(PROM_LEN));
    fill_last  = (hw == HW_W'(PROM_LEN - 1));
    issue_load = !dl_rise && wr_hit;
    issue_fill = !dl_rise && (state == ST_FILL);
    issue_data = issue_fill ? 8'hFF : ioctl_dout;
    hold_load  = !dl_rise &&
                 (((state == ST_LOAD) && dl_fall && hw_full) ||
                  (issue_fill && fill_last));
  end

  // Main FSM plus the registered PROM write port. A new download edge
  // overrides everything, including a fill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hw        <= '0;
      prog_en   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
    end else begin
      prog_en <= 1'b0;
      if (dl_rise) begin
        state <= ST_LOAD;
        hw    <= '0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (issue_load) begin
              prog_en   <= 1'b1;
              prog_addr <= off[PROM_AW-1:0];
              prog_data <= issue_data;
            end
            hw <= hw_next;
            if (dl_fall) state <= hw_full ? ST_DONE : ST_FILL;
          end
          ST_FILL: begin
            prog_en   <= 1'b1;
            prog_addr <= hw[PROM_AW-1:0];
            prog_data <= issue_data;
            hw        <= hw + HW_W'(1);
            if (fill_last) state <= ST_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  jtcop_prot_holdoff u_holdoff (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (dl_rise),
    .load     (hold_load),
    .load_val (HOLD_W'(HOLDOFF)),
    .en       (state == ST_DONE),
    .done     (hold_done)
  );

  assign ready    = (state == ST_DONE) && hold_done;
  assign prot_rst = !ready;

`ifdef JTCOP_PROT_CKSUM_EN
  // Running sum of every byte issued on the PROM port; no writes are
  // issued in DONE, so the value holds there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cksum <= 8'h00;
    else if (dl_rise)                  cksum <= 8'h00;
    else if (issue_load || issue_fill) cksum <= cksum + issue_data;
  end
`endif

endmodule

// File: tb/tb_jtcop_prot_loader.sv
// Bench for jtcop_prot_loader with PROM_START=22'h100, HOLDOFF=16.
// Drivers push expected PROM writes into exp_q; a monitor pops and compares
// them whenever prog_en is seen.
module tb_jtcop_prot_loader;

  localparam logic [21:0] START = 22'h100;
  localparam int          HOLD  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [21:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic [8:0]  prog_addr;
  logic [7:0]  prog_data;
  logic        prog_en;
  logic        prot_rst;
  logic        ready;
`ifdef JTCOP_PROT_CKSUM_EN
  logic [7:0]  cksum;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_exp;
  int          model_hw = 0;
  logic [7:0]  model_sum = 8'h00;

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  jtcop_prot_loader #(
    .PROM_START (START),
    .HOLDOFF    (HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_en     (prog_en),
    .prot_rst    (prot_rst),
    .ready       (ready)
`ifdef JTCOP_PROT_CKSUM_EN
    ,
    .cksum       (cksum)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every PROM write must match the head of the expected queue
  always @(negedge clk) begin
    if (prog_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL prog_write_unexpected: got addr %0h data %0h expected no write",
                 prog_addr, prog_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("prog_write", {15'd0, prog_addr, prog_data}, {15'd0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of one strobe: in-window bytes are expected on the PROM port
  task automatic note_write(input logic [21:0] addr, input logic [7:0] data);
    logic [21:0] off;
    if (addr >= START && addr < START + 22'd512) begin
      off = addr - START;
      exp_q.push_back({off[8:0], data});
      if (int'(off) + 1 > model_hw) model_hw = int'(off) + 1;
      model_sum = model_sum + data;
    end
  endtask

  task automatic start_dl();
    downloading = 1'b1;
    tick();
    model_hw  = 0;
    model_sum = 8'h00;
    check("start_prot_rst", prot_rst, 1);
    check("start_ready", ready, 0);
  endtask

  task automatic wr(input logic [21:0] addr, input logic [7:0] data);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    note_write(addr, data);
    tick();
    ioctl_wr = 1'b0;
  endtask

  // Drop downloading (optionally with a coincident strobe), expect the fill
  // and check ready rises exactly fill + HOLD cycles after the falling edge.
  task automatic end_dl(input bit with_wr, input logic [21:0] addr, input logic [7:0] data);
    int exp_cyc;
    bit early;
    downloading = 1'b0;
    if (with_wr) begin
      ioctl_addr = addr;
      ioctl_dout = data;
      ioctl_wr   = 1'b1;
      note_write(addr, data);
    end
    tick();
    ioctl_wr = 1'b0;
    exp_cyc = (512 - model_hw) + HOLD;
    for (int a = model_hw; a < 512; a++) begin
      exp_q.push_back({9'(a), 8'hFF});
      model_sum = model_sum + 8'hFF;
    end
    early = 1'b0;
    for (int i = 1; i <= exp_cyc; i++) begin
      if (ready !== 1'b0 || prot_rst !== 1'b1) early = 1'b1;
      tick();
    end
    check("ready_early", {31'd0, early}, 0);
    check("ready_rise", ready, 1);
    check("prot_rst_fall", prot_rst, 0);
    check("queue_drained", exp_q.size(), 0);
`ifdef JTCOP_PROT_CKSUM_EN
    check("cksum", cksum, model_sum);
`endif
  endtask

  // Directed sequence
  initial begin
    #2;
    check("rst_prog_en", prog_en, 0);
    check("rst_prog_addr", prog_addr, 0);
    check("rst_prog_data", prog_data, 0);
    check("rst_prot_rst", prot_rst, 1);
    check("rst_ready", ready, 0);
`ifdef JTCOP_PROT_CKSUM_EN
    check("rst_cksum", cksum, 0);
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("idle_prot_rst", prot_rst, 1);

    // Full image, two out-of-window strobes, last byte coincident with fall
    start_dl();
    wr(22'h0FF, 8'h11);
    wr(22'h300, 8'h22);
    for (int a = 'h100; a < 'h2FF; a++) wr(22'(a), 8'(a));
    end_dl(1'b1, 22'h2FF, 8'hFF);

    // Half image: fill pads offsets 100..1FF with FF
    repeat (3) tick();
    start_dl();
    for (int a = 'h100; a < 'h200; a++) wr(22'(a), 8'(a));
    end_dl(1'b0, '0, '0);

    // Fill interrupted by a new download edge after 20 fill writes
    repeat (3) tick();
    start_dl();
    for (int a = 'h100; a < 'h110; a++) wr(22'(a), 8'(a ^ 'h5A));
    downloading = 1'b0;
    tick();
    for (int a = 16; a < 36; a++) exp_q.push_back({9'(a), 8'hFF});
    repeat (20) tick();
    check("fill_prot_rst", prot_rst, 1);
    check("fill_ready", ready, 0);
    start_dl();
    wr(22'h105, 8'h3C);
    end_dl(1'b0, '0, '0);

    // Reset in the middle of a load
    repeat (3) tick();
    start_dl();
    wr(22'h100, 8'hAA);
    wr(22'h101, 8'hBB);
    tick();
    ioctl_addr = 22'h102;
    ioctl_dout = 8'hCC;
    ioctl_wr   = 1'b1;
    rst_n      = 1'b0;
    #1;
    check("midrst_prog_en", prog_en, 0);
    check("midrst_prog_addr", prog_addr, 0);
    check("midrst_prog_data", prog_data, 0);
    check("midrst_prot_rst", prot_rst, 1);
    check("midrst_ready", ready, 0);
    tick();
    rst_n = 1'b1;
    for (int a = 'h103; a < 'h110; a++) begin
      ioctl_addr = 22'(a);
      ioctl_dout = 8'(a);
      tick();
    end
    ioctl_wr    = 1'b0;
    downloading = 1'b0;
    repeat (5) tick();
    check("postrst_ready", ready, 0);
    check("postrst_prot_rst", prot_rst, 1);
    start_dl();
    wr(22'h2FF, 8'h77);
    end_dl(1'b0, '0, '0);

    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
